// File: rtl/dcache_ctrl_if.sv
// Pipeline-side request/response bundle for the data cache.
// master = memory stage, slave = cache controller.
interface dcache_ctrl_if;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        rd;
   logic        wr;
   logic [15:0] rdata;
   logic        done;
   logic        stall;
   logic        cache_hit;
   logic        err;

   modport master (
      output addr, wdata, rd, wr,
      input  rdata, done, stall, cache_hit, err
   );

   modport slave (
      input  addr, wdata, rd, wr,
      output rdata, done, stall, cache_hit, err
   );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache, 4 words of 16 bits per line.
// Hits answer combinationally in IDLE; misses write back a dirty victim, then refill.
module dcache_ctrl #(
   parameter int INDEX_BITS = 8,
   parameter int MEM_LAT    = 2
) (
   input  logic               clk,
   input  logic               rst,
   dcache_ctrl_if.slave       cpu,
   output logic [15:0]        mem_addr,
   output logic [15:0]        mem_wdata,
   output logic               mem_wr,
   output logic               mem_rd,
   input  logic [15:0]        mem_rdata
);
   localparam int TAG_BITS = 13 - INDEX_BITS;
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int CNT_W    = (MEM_LAT > 4) ? $clog2(MEM_LAT) : 2;

   typedef enum logic [2:0] {S_IDLE, S_WB, S_RD, S_WAIT, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [14:0]             word_q, word_d;
   logic [15:0]             wdata_q, wdata_d;
   logic                    is_rd_q, is_rd_d;
   logic [MEM_LAT-1:0]      pipe_q, pipe_d;
   logic [1:0]              cap_q, cap_d;
   logic [LINES-1:0]        valid_q, valid_d;
   logic [LINES-1:0]        dirty_q, dirty_d;

   logic [15:0]             data_mem [0:LINES*4-1];
   logic [TAG_BITS-1:0]     tag_mem  [0:LINES-1];

   logic [14:0]             cur_word;
   logic [INDEX_BITS-1:0]   idx;
   logic [TAG_BITS-1:0]     tag;
   logic [1:0]              off;
   logic [1:0]              rd_off;
   logic [TAG_BITS-1:0]     line_tag;
   logic [15:0]             rd_word;
   logic                    tag_hit;
   logic                    victim_dirty;

   logic                    data_we;
   logic [INDEX_BITS+1:0]   data_wa;
   logic [15:0]             data_wd;
   logic                    tag_we;

   logic [15:0]             rdata_c;
   logic                    done_c, stall_c, hit_c, err_c;

   // Decode from the live request in IDLE, from the latched request otherwise.
   assign cur_word     = (state_q == S_IDLE) ? cpu.addr[15:1] : word_q;
   assign idx          = cur_word[2 +: INDEX_BITS];
   assign tag          = cur_word[14 -: TAG_BITS];
   assign off          = cur_word[1:0];
   assign rd_off       = (state_q == S_WB) ? cnt_q[1:0] : off;
   assign line_tag     = tag_mem[idx];
   assign rd_word      = data_mem[{idx, rd_off}];
   assign tag_hit      = valid_q[idx] && (line_tag == tag);
   assign victim_dirty = valid_q[idx] && dirty_q[idx];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      word_d    = word_q;
      wdata_d   = wdata_q;
      is_rd_d   = is_rd_q;
      cap_d     = cap_q;
      valid_d   = valid_q;
      dirty_d   = dirty_q;
      data_we   = 1'b0;
      data_wa   = {idx, off};
      data_wd   = cpu.wdata;
      tag_we    = 1'b0;
      rdata_c   = 16'h0;
      done_c    = 1'b0;
      stall_c   = 1'b0;
      hit_c     = 1'b0;
      err_c     = 1'b0;
      mem_addr  = 16'h0;
      mem_wdata = 16'h0;
      mem_wr    = 1'b0;
      mem_rd    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cpu.rd || cpu.wr) begin
               if (cpu.addr[0] || (cpu.rd && cpu.wr)) begin
                  done_c = 1'b1;
                  err_c  = 1'b1;
               end else if (tag_hit) begin
                  done_c = 1'b1;
                  hit_c  = 1'b1;
                  if (cpu.rd) begin
                     rdata_c = rd_word;
                  end else begin
                     data_we      = 1'b1;
                     dirty_d[idx] = 1'b1;
                  end
               end else begin
                  // The line is about to be overwritten, so drop it now.
                  stall_c      = 1'b1;
                  word_d       = cpu.addr[15:1];
                  wdata_d      = cpu.wdata;
                  is_rd_d      = cpu.rd;
                  cnt_d        = '0;
                  cap_d        = 2'd0;
                  valid_d[idx] = 1'b0;
                  dirty_d[idx] = 1'b0;
                  state_d      = victim_dirty ? S_WB : S_RD;
               end
            end
         end
         S_WB: begin
            stall_c   = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = {line_tag, idx, cnt_q[1:0], 1'b0};
            mem_wdata = rd_word;
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q[1:0] == 2'd3) begin
               cnt_d   = '0;
               state_d = S_RD;
            end
         end
         S_RD: begin
            stall_c  = 1'b1;
            mem_rd   = 1'b1;
            mem_addr = {tag, idx, cnt_q[1:0], 1'b0};
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q[1:0] == 2'd3) begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            stall_c = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_c       = 1'b1;
            tag_we       = 1'b1;
            valid_d[idx] = 1'b1;
            dirty_d[idx] = !is_rd_q;
            if (is_rd_q) begin
               rdata_c = rd_word;
            end else begin
               data_we = 1'b1;
               data_wd = wdata_q;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Refill words arrive MEM_LAT cycles after their read strobe, in issue order.
      pipe_d = MEM_LAT'({pipe_q, mem_rd});
      if (pipe_q[MEM_LAT-1]) begin
         data_we = 1'b1;
         data_wa = {idx, cap_q};
         data_wd = mem_rdata;
         cap_d   = cap_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         word_q  <= '0;
         wdata_q <= '0;
         is_rd_q <= 1'b0;
         pipe_q  <= '0;
         cap_q   <= 2'd0;
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         wdata_q <= wdata_d;
         is_rd_q <= is_rd_d;
         pipe_q  <= pipe_d;
         cap_q   <= cap_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (data_we) begin
         data_mem[data_wa] <= data_wd;
      end
      if (tag_we) begin
         tag_mem[idx] <= tag;
      end
   end

   assign cpu.rdata     = rdata_c;
   assign cpu.done      = done_c;
   assign cpu.stall     = stall_c;
   assign cpu.cache_hit = hit_c;
   assign cpu.err       = err_c;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: expected responses and memory traffic are queued
// when a request is driven and compared as the cache answers and the bus moves.
module tb_dcache_ctrl;
   localparam int MEM_LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_wr, mem_rd;

   always #5 clk = ~clk;

   dcache_ctrl_if cpu();

   dcache_ctrl #(.INDEX_BITS(8), .MEM_LAT(MEM_LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu       (cpu),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wr    (mem_wr),
      .mem_rd    (mem_rd),
      .mem_rdata (mem_rdata)
   );

   typedef struct {
      logic        is_wr;
      logic [15:0] addr;
      logic [15:0] data;
   } mem_op_t;

   typedef struct {
      logic [15:0] rdata;
      logic        chk_rdata;
      logic        hit;
      logic        err;
      int          lat;
   } resp_t;

   mem_op_t     mem_q[$];
   resp_t       sb_q[$];
   logic [15:0] tbmem [0:32767];
   logic [15:0] gold  [0:32767];
   logic [15:0] lat_pipe [0:MEM_LAT-1];
   int          n_vec = 0;
   int          n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] init_word(input int w);
      return 16'(w * 3) ^ 16'hA5C3;
   endfunction

   // Word-addressed memory with a MEM_LAT-deep read pipeline.
   always @(posedge clk) begin
      if (mem_wr) tbmem[mem_addr[15:1]] <= mem_wdata;
      lat_pipe[0] <= mem_rd ? tbmem[mem_addr[15:1]] : 16'hDEAD;
      for (int i = 1; i < MEM_LAT; i++) lat_pipe[i] <= lat_pipe[i-1];
   end
   assign mem_rdata = lat_pipe[MEM_LAT-1];

   always @(negedge clk) begin
      if (mem_rd || mem_wr) begin
         if (mem_q.size() == 0) begin
            check_eq("mem_unexpected", {14'b0, mem_wr, mem_rd, mem_addr}, 32'h0);
         end else begin
            mem_op_t e;
            e = mem_q.pop_front();
            check_eq("mem_kind", {31'b0, mem_wr}, {31'b0, e.is_wr});
            check_eq("mem_addr", {16'b0, mem_addr}, {16'b0, e.addr});
            if (e.is_wr) check_eq("mem_wdata", {16'b0, mem_wdata}, {16'b0, e.data});
         end
      end
   end

   task automatic push_fill(input logic [15:0] base);
      for (int k = 0; k < 4; k++) mem_q.push_back('{1'b0, 16'(base + 16'(2*k)), 16'h0});
   endtask

   task automatic push_wb(input logic [15:0] base);
      for (int k = 0; k < 4; k++)
         mem_q.push_back('{1'b1, 16'(base + 16'(2*k)), gold[int'(base[15:1]) + k]});
   endtask

   // Drives one request starting just after a posedge, waits for done, scores it.
   task automatic run_req(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic e_hit, input logic e_err, input int e_lat);
      resp_t e;
      resp_t g;
      int    cyc;
      logic  stall_ok;
      e.rdata     = gold[a[15:1]];
      e.chk_rdata = r && !w && !e_err;
      e.hit       = e_hit;
      e.err       = e_err;
      e.lat       = e_lat;
      sb_q.push_back(e);
      if (w && !r && !e_err) gold[a[15:1]] = d;
      cpu.addr  = a;
      cpu.wdata = d;
      cpu.rd    = r;
      cpu.wr    = w;
      cyc      = 0;
      stall_ok = 1'b1;
      @(negedge clk);
      while (!cpu.done && cyc < 40) begin
         if (!cpu.stall) stall_ok = 1'b0;
         @(negedge clk);
         cyc++;
      end
      g = sb_q.pop_front();
      check_eq("done_seen", {31'b0, cpu.done}, 32'd1);
      check_eq("latency", cyc, g.lat);
      check_eq("cache_hit", {31'b0, cpu.cache_hit}, {31'b0, g.hit});
      check_eq("err", {31'b0, cpu.err}, {31'b0, g.err});
      check_eq("stall_at_done", {31'b0, cpu.stall}, 32'd0);
      check_eq("stall_while_busy", {31'b0, stall_ok}, 32'd1);
      if (g.chk_rdata) check_eq("rdata", {16'b0, cpu.rdata}, {16'b0, g.rdata});
      $display("req rd=%0b wr=%0b addr=%h wdata=%h -> lat=%0d hit=%0b err=%0b rdata=%h",
               r, w, a, d, cyc, cpu.cache_hit, cpu.err, cpu.rdata);
      @(posedge clk);
      #1;
      cpu.rd = 1'b0;
      cpu.wr = 1'b0;
   endtask

   task automatic check_idle_zero(input string tag);
      check_eq(tag, {10'b0, cpu.done, cpu.stall, cpu.cache_hit, cpu.err, mem_rd, mem_wr, cpu.rdata},
               32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32768; i++) begin
         tbmem[i] = init_word(i);
         gold[i]  = init_word(i);
      end
      for (int i = 0; i < MEM_LAT; i++) lat_pipe[i] = 16'hDEAD;
      rst       = 1'b1;
      cpu.addr  = 16'h0;
      cpu.wdata = 16'h0;
      cpu.rd    = 1'b0;
      cpu.wr    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle_zero("reset_outputs");
      @(posedge clk);
      #1;
      rst = 1'b0;

      push_fill(16'h0010);
      run_req(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 7);
      run_req(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 0);
      run_req(1'b0, 1'b1, 16'h0012, 16'hBEEF, 1'b1, 1'b0, 0);
      run_req(1'b1, 1'b0, 16'h0012, 16'h0, 1'b1, 1'b0, 0);

      // 0x0812 shares the index of 0x0012: dirty victim goes out first.
      push_wb(16'h0010);
      push_fill(16'h0810);
      run_req(1'b1, 1'b0, 16'h0812, 16'h0, 1'b0, 1'b0, 11);
      push_fill(16'h0010);
      run_req(1'b1, 1'b0, 16'h0012, 16'h0, 1'b0, 1'b0, 7);

      run_req(1'b1, 1'b0, 16'h0013, 16'h0, 1'b0, 1'b1, 0);
      run_req(1'b1, 1'b1, 16'h0040, 16'h5555, 1'b0, 1'b1, 0);
      run_req(1'b0, 1'b1, 16'h0015, 16'h7777, 1'b0, 1'b1, 0);

      // Reset while the refill is in RD2.
      mem_q.push_back('{1'b0, 16'h0030, 16'h0});
      mem_q.push_back('{1'b0, 16'h0032, 16'h0});
      mem_q.push_back('{1'b0, 16'h0034, 16'h0});
      cpu.addr = 16'h0030;
      cpu.rd   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rd2_stall", {31'b0, cpu.stall}, 32'd1);
      rst    = 1'b1;
      cpu.rd = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_idle_zero("after_mid_reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      $display("req rst during RD2 of ld 0030 -> outputs idle");

      push_fill(16'h0030);
      run_req(1'b1, 1'b0, 16'h0030, 16'h0, 1'b0, 1'b0, 7);
      push_fill(16'h0010);
      run_req(1'b1, 1'b0, 16'h0012, 16'h0, 1'b0, 1'b0, 7);

      push_fill(16'h0020);
      run_req(1'b0, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0, 7);
      run_req(1'b1, 1'b0, 16'h0020, 16'h0, 1'b1, 1'b0, 0);
      push_wb(16'h0020);
      push_fill(16'h0820);
      run_req(1'b1, 1'b0, 16'h0826, 16'h0, 1'b0, 1'b0, 11);
      push_fill(16'h0020);
      run_req(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b0, 7);

      repeat (4) @(posedge clk);
      check_eq("mem_traffic_drained", mem_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
